// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Generates 640x480@60 style VGA timing from a single 50 MHz system clock.
// An internal enable toggles every Clk, so each pixel count lasts exactly
// two Clk cycles; the same enable is exported as the DAC pixel clock.
// Sync, blank and cell outputs are decoded from the next counter values and
// registered, so they line up with DrawX/DrawY on every cycle with no skew.
//
// Ports
//   Clk          in   1   system clock
//   Reset_n      in   1   asynchronous active-low reset
//   pixel_clk    out  1   registered divide-by-2 of Clk
//   hs           out  1   horizontal sync, active-low
//   vs           out  1   vertical sync, active-low
//   blank        out  1   display enable, 1 = visible region
//   DrawX        out  10  horizontal count, 0..H_TOTAL-1
//   DrawY        out  10  vertical count, 0..V_TOTAL-1
//   CellX        out  7   DrawX >> CELL_SHIFT (truncated, no saturation)
//   CellY        out  6   DrawY >> CELL_SHIFT (truncated, no saturation)
//   frame_start  out  1   one-Clk pulse when the counters wrap to (0,0)
//   frame_count  out  8   frames completed since reset, modulo 256
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned CELL_SHIFT = 3
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       pixel_clk,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic [6:0] CellX,
   output logic [5:0] CellY,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Counter-width copies of the timing points, so every compare is 10 bits.
   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic       pix_en_r;
   logic [9:0] x_r;
   logic [9:0] y_r;
   logic       hs_r;
   logic       vs_r;
   logic       blank_r;
   logic [6:0] cell_x_r;
   logic [5:0] cell_y_r;
   logic       frame_start_r;
   logic [7:0] frame_count_r;

   logic       h_wrap_s;
   logic       v_wrap_s;
   logic       frame_wrap_s;
   logic [9:0] next_x_s;
   logic [9:0] next_y_s;
   logic       hs_next_s;
   logic       vs_next_s;
   logic       blank_next_s;

   // Next counter values; counts move only when the pixel enable is high.
   always_comb begin
      h_wrap_s = (x_r == H_LAST);
      v_wrap_s = (y_r == V_LAST);
      next_x_s = x_r;
      next_y_s = y_r;
      if (pix_en_r) begin
         if (h_wrap_s) begin
            next_x_s = 10'd0;
            if (v_wrap_s) begin
               next_y_s = 10'd0;
            end else begin
               next_y_s = y_r + 10'd1;
            end
         end else begin
            next_x_s = x_r + 10'd1;
            next_y_s = y_r;
         end
      end else begin
         next_x_s = x_r;
         next_y_s = y_r;
      end
      frame_wrap_s = pix_en_r & h_wrap_s & v_wrap_s;
   end

   // Sync and display-enable decode of the next counter position.
   always_comb begin
      hs_next_s    = ~((next_x_s >= H_SYNC_FIRST) && (next_x_s <= H_SYNC_LAST));
      vs_next_s    = ~((next_y_s >= V_SYNC_FIRST) && (next_y_s <= V_SYNC_LAST));
      blank_next_s = (next_x_s < H_VIS_END) && (next_y_s < V_VIS_END);
   end

   // Pixel enable, counters and all registered timing outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_en_r      <= 1'b0;
         x_r           <= 10'd0;
         y_r           <= 10'd0;
         hs_r          <= 1'b1;
         vs_r          <= 1'b1;
         blank_r       <= 1'b1;
         cell_x_r      <= 7'd0;
         cell_y_r      <= 6'd0;
         frame_start_r <= 1'b0;
         frame_count_r <= 8'd0;
      end else begin
         pix_en_r      <= ~pix_en_r;
         x_r           <= next_x_s;
         y_r           <= next_y_s;
         hs_r          <= hs_next_s;
         vs_r          <= vs_next_s;
         blank_r       <= blank_next_s;
         // Plain truncation: off-screen counts may exceed the visible grid.
         cell_x_r      <= 7'(next_x_s >> CELL_SHIFT);
         cell_y_r      <= 6'(next_y_s >> CELL_SHIFT);
         frame_start_r <= frame_wrap_s;
         if (frame_wrap_s) begin
            frame_count_r <= frame_count_r + 8'd1;
         end else begin
            frame_count_r <= frame_count_r;
         end
      end
   end

   assign pixel_clk   = pix_en_r;
   assign DrawX       = x_r;
   assign DrawY       = y_r;
   assign hs          = hs_r;
   assign vs          = vs_r;
   assign blank       = blank_r;
   assign CellX       = cell_x_r;
   assign CellY       = cell_y_r;
   assign frame_start = frame_start_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench. Instance u_full uses the default 640x480 timing and covers
// the horizontal behaviour over the first lines. Instance u_small uses a
// reduced 32x15 raster (frame = 960 Clk) so vertical sync, frame pulses,
// frame_count and mid-frame reset are reached within a short run.
// Edge numbers count Clk rising edges after reset release; outputs are
// sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk;
   logic rst_n_a;
   logic rst_n_b;

   logic       pclk_a, hs_a, vs_a, blank_a, fs_a;
   logic [9:0] x_a, y_a;
   logic [6:0] cx_a;
   logic [5:0] cy_a;
   logic [7:0] fc_a;

   logic       pclk_b, hs_b, vs_b, blank_b, fs_b;
   logic [9:0] x_b, y_b;
   logic [6:0] cx_b;
   logic [5:0] cy_b;
   logic [7:0] fc_b;

   int n_checks;
   int n_errors;
   int edge_n;
   int fs_cnt_a;
   int fs_cnt_b;

   vga_timing_gen u_full (
      .Clk(clk), .Reset_n(rst_n_a), .pixel_clk(pclk_a), .hs(hs_a), .vs(vs_a),
      .blank(blank_a), .DrawX(x_a), .DrawY(y_a), .CellX(cx_a), .CellY(cy_a),
      .frame_start(fs_a), .frame_count(fc_a)
   );

   // Small raster: H 16/4/6/6 = 32, V 8/2/2/3 = 15, 4x4 cells.
   // hs low for x 20..25, vs low for y 10..11, visible x<16 and y<8.
   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .CELL_SHIFT(2)
   ) u_small (
      .Clk(clk), .Reset_n(rst_n_b), .pixel_clk(pclk_b), .hs(hs_b), .vs(vs_b),
      .blank(blank_b), .DrawX(x_b), .DrawY(y_b), .CellX(cx_b), .CellY(cy_b),
      .frame_start(fs_b), .frame_count(fc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count frame_start pulses once per Clk cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (fs_a) fs_cnt_a++;
      if (fs_b) fs_cnt_b++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, edge_n);
      end
   endtask

   task automatic run_to(input int target);
      while (edge_n < target) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      edge_n   = 0;
      fs_cnt_a = 0;
      fs_cnt_b = 0;
      rst_n_a  = 1'b0;
      rst_n_b  = 1'b0;
      #22;

      // Reset state of the full-size instance.
      check_val("rst_x",     32'(x_a),    32'd0);
      check_val("rst_y",     32'(y_a),    32'd0);
      check_val("rst_hs",    32'(hs_a),   32'd1);
      check_val("rst_vs",    32'(vs_a),   32'd1);
      check_val("rst_blank", 32'(blank_a),32'd1);
      check_val("rst_cell",  32'({cx_a, cy_a}), 32'd0);
      check_val("rst_fs",    32'(fs_a),   32'd0);
      check_val("rst_fc",    32'(fc_a),   32'd0);
      check_val("rst_pclk",  32'(pclk_a), 32'd0);

      // ---------------- full-size horizontal timing ----------------
      @(negedge clk);
      rst_n_a = 1'b1;
      edge_n  = 0;
      run_to(1);
      check_val("e1_x",    32'(x_a),    32'd0);
      check_val("e1_pclk", 32'(pclk_a), 32'd1);
      run_to(2);
      check_val("e2_x",    32'(x_a),    32'd1);
      check_val("e2_pclk", 32'(pclk_a), 32'd0);
      run_to(1279);
      check_val("x639",       32'(x_a),     32'd639);
      check_val("x639_blank", 32'(blank_a), 32'd1);
      check_val("x639_cellx", 32'(cx_a),    32'd79);
      run_to(1280);
      check_val("x640_blank", 32'(blank_a), 32'd0);
      run_to(1311);
      check_val("x655",    32'(x_a),  32'd655);
      check_val("x655_hs", 32'(hs_a), 32'd1);
      run_to(1312);
      check_val("x656",    32'(x_a),  32'd656);
      check_val("x656_hs", 32'(hs_a), 32'd0);
      run_to(1503);
      check_val("x751_hs", 32'(hs_a), 32'd0);
      run_to(1504);
      check_val("x752",    32'(x_a),  32'd752);
      check_val("x752_hs", 32'(hs_a), 32'd1);
      run_to(1598);
      check_val("x799",       32'(x_a),     32'd799);
      check_val("x799_y",     32'(y_a),     32'd0);
      check_val("x799_blank", 32'(blank_a), 32'd0);
      check_val("x799_cellx", 32'(cx_a),    32'd99);
      run_to(1600);
      check_val("wrap_x",     32'(x_a),     32'd0);
      check_val("wrap_y",     32'(y_a),     32'd1);
      check_val("wrap_blank", 32'(blank_a), 32'd1);
      check_val("wrap_vs",    32'(vs_a),    32'd1);
      // DrawX=17, DrawY=9
      run_to(14434);
      check_val("p17_9_x",     32'(x_a),     32'd17);
      check_val("p17_9_y",     32'(y_a),     32'd9);
      check_val("p17_9_cellx", 32'(cx_a),    32'd2);
      check_val("p17_9_celly", 32'(cy_a),    32'd1);
      check_val("p17_9_blank", 32'(blank_a), 32'd1);
      check_val("full_fc",     32'(fc_a),    32'd0);
      check_val("full_fs_cnt", 32'(fs_cnt_a), 32'd0);
      rst_n_a = 1'b0;

      // ---------------- small raster: vertical, frames ----------------
      @(negedge clk);
      rst_n_b = 1'b1;
      edge_n  = 0;
      run_to(39);
      check_val("s_x19_hs", 32'(hs_b), 32'd1);
      run_to(40);
      check_val("s_x20_hs", 32'(hs_b), 32'd0);
      run_to(51);
      check_val("s_x25_hs", 32'(hs_b), 32'd0);
      run_to(52);
      check_val("s_x26_hs", 32'(hs_b), 32'd1);
      run_to(332);
      check_val("s_p6_5_cell",  32'({cx_b, cy_b}), 32'({7'd1, 6'd1}));
      check_val("s_p6_5_blank", 32'(blank_b), 32'd1);
      run_to(510);
      check_val("s_y7_blank", 32'(blank_b), 32'd0);
      run_to(512);
      check_val("s_y8",       32'(y_b),     32'd8);
      check_val("s_y8_blank", 32'(blank_b), 32'd0);
      run_to(639);
      check_val("s_y9_vs", 32'(vs_b), 32'd1);
      run_to(640);
      check_val("s_y10",    32'(y_b),  32'd10);
      check_val("s_y10_vs", 32'(vs_b), 32'd0);
      run_to(767);
      check_val("s_y11_vs", 32'(vs_b), 32'd0);
      run_to(768);
      check_val("s_y12_vs", 32'(vs_b), 32'd1);
      run_to(958);
      check_val("s_last_xy",    32'({x_b, y_b}),   32'({10'd31, 10'd14}));
      check_val("s_last_cell",  32'({cx_b, cy_b}), 32'({7'd7, 6'd3}));
      run_to(959);
      check_val("s_pre_fs", 32'(fs_b), 32'd0);
      run_to(960);
      check_val("s_f1_xy", 32'({x_b, y_b}), 32'd0);
      check_val("s_f1_fs", 32'(fs_b), 32'd1);
      check_val("s_f1_fc", 32'(fc_b), 32'd1);
      run_to(961);
      check_val("s_f1_fs_end", 32'(fs_b), 32'd0);
      run_to(1920);
      check_val("s_f2_fc", 32'(fc_b), 32'd2);
      run_to(2880);
      check_val("s_f3_fs", 32'(fs_b), 32'd1);
      check_val("s_f3_fc", 32'(fc_b), 32'd3);
      run_to(2881);
      check_val("s_fs_cnt3", 32'(fs_cnt_b), 32'd3);

      // Mid-frame reset at DrawY=5, DrawX=3.
      run_to(3206);
      check_val("s_mid_xy", 32'({x_b, y_b}), 32'({10'd3, 10'd5}));
      rst_n_b = 1'b0;
      #1;
      check_val("s_ar_xy",    32'({x_b, y_b}), 32'd0);
      check_val("s_ar_fc",    32'(fc_b),    32'd0);
      check_val("s_ar_sync",  32'({hs_b, vs_b, blank_b}), 32'd7);
      check_val("s_ar_pclk",  32'(pclk_b),  32'd0);
      check_val("s_ar_cell",  32'({cx_b, cy_b}), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n_b = 1'b1;
      edge_n  = 0;
      run_to(2);
      check_val("s_rr_x", 32'(x_b), 32'd1);
      run_to(959);
      check_val("s_rr_fs_cnt", 32'(fs_cnt_b), 32'd3);
      check_val("s_rr_pre_fs", 32'(fs_b), 32'd0);
      run_to(960);
      check_val("s_rr_fs", 32'(fs_b), 32'd1);
      check_val("s_rr_fc", 32'(fc_b), 32'd1);
      run_to(961);
      check_val("s_rr_fs_cnt4", 32'(fs_cnt_b), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels; H_TOTAL = sum of the four, 800 by default.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines; V_TOTAL = sum of the four, 525 by default.
REQ-009 Parameter CELL_SHIFT, default 3, log2 of the grid cell size in pixels (8x8 cells, 80x60 grid).
REQ-010 Clk  input  1  system clock (50 MHz); the design has one clock and reset is asynchronous, active-low.
REQ-011 Reset_n  input  1  asynchronous active-low reset.
REQ-012 pixel_clk  output  1  registered divide-by-2 of Clk, driven to the VGA DAC.
REQ-013 hs  output  1  horizontal sync, active-low.
REQ-014 vs  output  1  vertical sync, active-low.
REQ-015 blank  output  1  display-enable: 1 = visible region, 0 = porch or sync (pixel consumers draw only when 1).
REQ-016 DrawX  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-017 DrawY  output  10  current vertical count, 0..V_TOTAL-1.
REQ-018 CellX  output  7  DrawX >> CELL_SHIFT.
REQ-019 CellY  output  6  DrawY >> CELL_SHIFT.
REQ-020 frame_start  output  1  one-Clk pulse when the counters wrap to (0,0).
REQ-021 frame_count  output  8  frames completed since reset, modulo 256.

Function
REQ-022 Internal pix_en toggles on every Clk rising edge; pixel_clk equals pix_en.
REQ-023 Counters advance only on Clk edges where pix_en is 1 before the edge; each count therefore lasts exactly 2 Clk.
REQ-024 Horizontal counter: increments 0..H_TOTAL-1, then wraps to 0.
REQ-025 Vertical counter: increments only on a horizontal wrap, runs 0..V_TOTAL-1, then wraps to 0.
REQ-026 hs is 0 iff DrawX is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
REQ-027 vs is 0 iff DrawY is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
REQ-028 blank is 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-029 hs, vs, blank, CellX and CellY are registered and decoded from the next counter values, so they always correspond to the DrawX/DrawY on the same cycle, with zero skew.
REQ-030 CellX and CellY are meaningful only while blank=1; outside the visible region they are the truncated shift of the count, with no saturation.
REQ-031 Simultaneous horizontal and vertical wrap (799,524 -> 0,0): on the same edge, frame_start=1 for exactly one Clk and frame_count increments.
REQ-032 frame_count wraps 255 -> 0 with no flag.
REQ-033 All arithmetic is unsigned; counters never take a value of H_TOTAL or V_TOTAL or above.

Reset
REQ-034 While Reset_n=0, asynchronously: pix_en=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=1, CellX=0, CellY=0, frame_start=0, frame_count=0.
REQ-035 Reset asserted mid-frame aborts immediately; after release, timing restarts from (0,0) and the first count advance occurs on the 2nd Clk edge.
REQ-036 No frame_start pulse is generated by reset or by its release.

Verification
REQ-037 Reset release, count Clk edges -> DrawX=1 after edge 2, DrawX=656 and hs=0 after edge 1312, hs=1 after edge 1504.
REQ-038 Run one line (1600 Clk) -> DrawX wraps 799 -> 0, DrawY 0 -> 1; blank=0 for DrawX 640..799.
REQ-039 Run to line 490 -> vs=0 for exactly 2 lines (3200 Clk); blank=0 for all lines 480..524.
REQ-040 Run 3 full frames (840000 Clk each) -> frame_start pulses at edges 840000, 1680000, 2520000, each 1 Clk wide; frame_count=3.
REQ-041 At DrawX=17, DrawY=9 -> CellX=2, CellY=1, blank=1; at DrawX=639, DrawY=479 -> CellX=79, CellY=59.
REQ-042 Assert Reset_n=0 at DrawY=300 for 3 Clk -> all outputs take REQ-034 values immediately, frame_count=0, and the next frame_start occurs 840000 Clk after release.
